// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_sync_pipe memory: FSM states, latency bound,
// byte-lane count and per-lane parity.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int MAX_RD_LAT = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic lane_parity(input logic [7:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Storage array: registered write with per-lane enables, combinational read of the
// addressed word. Address range checking is the caller's job.
module sram_array #(
  parameter int LANES  = 1,
  parameter int LANE_W = 8,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 256
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [LANES-1:0]             be_i,
  input  logic [IDX_W-1:0]             waddr_i,
  input  logic [LANES-1:0][LANE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]             raddr_i,
  output logic [LANES-1:0][LANE_W-1:0] rdata_o
);

  logic [LANES-1:0][LANE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (be_i[l]) mem_q[waddr_i][l] <= wdata_i[l];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_sync_pipe.sv
// Single-port SRAM with byte-lane writes, RD_LAT-deep read pipeline and a zeroing sweep
// after reset. Define SRAM_PARITY_EN to store per-lane parity and expose ParityErr.
module sram_sync_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                ChipSelect,
  input  logic                WriteEnable,
  input  logic                ReadEnable,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic                ReqReady,
  output logic                Busy,
  output logic [DATA_W-1:0]   dataOut,
  output logic                ReadValid,
`ifdef SRAM_PARITY_EN
  output logic                ParityErr,
`endif
  output sram_state_e         dbg_state_o
);

  localparam int LANES = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef SRAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  sram_state_e                  state_q;
  logic [IDX_W-1:0]             ptr_q;
  logic                         ready_q, busy_q;
  logic                         in_range, accept, rd_acc, wr_acc;
  logic                         arr_we;
  logic [LANES-1:0]             arr_be;
  logic [IDX_W-1:0]             arr_waddr;
  logic [LANES-1:0][LANE_W-1:0] arr_wdata, arr_rdata;
  logic [DATA_W-1:0]            rd_data;
  logic [LAT-1:0]               vld_q;
  logic [LAT-1:0][DATA_W-1:0]   dat_q;

  assign in_range = {1'b0, Addr} < DEPTH_L;
  assign accept   = ChipSelect & ready_q & (WriteEnable | ReadEnable);
  assign rd_acc   = accept & ReadEnable;
  assign wr_acc   = accept & WriteEnable & in_range;

  // The clear sweep owns the write port; zero data also means zero parity.
  always_comb begin
    arr_we    = wr_acc;
    arr_be    = ByteEn;
    arr_waddr = Addr[IDX_W-1:0];
    arr_wdata = '0;
    rd_data   = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef SRAM_PARITY_EN
      arr_wdata[l] = {lane_parity(dataIn[8*l +: 8]), dataIn[8*l +: 8]};
`else
      arr_wdata[l] = dataIn[8*l +: 8];
`endif
      rd_data[8*l +: 8] = arr_rdata[l][7:0];
    end
    if (state_q == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_waddr = ptr_q;
      arr_wdata = '0;
    end
    if (!in_range) rd_data = '0;
  end

  sram_array #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i  (Clock),
    .we_i   (arr_we),
    .be_i   (arr_be),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .raddr_i(Addr[IDX_W-1:0]),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      if (ptr_q == IDX_W'(DEPTH - 1)) begin
        state_q <= ST_READY;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        ptr_q <= ptr_q + IDX_W'(1);
      end
    end
  end

  // Each stage's data only advances behind a valid, so the last stage holds the last read.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= rd_data;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic           perr_now;
  logic [LAT-1:0] perr_q;

  always_comb begin
    perr_now = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (arr_rdata[l][8] != lane_parity(arr_rdata[l][7:0])) perr_now = 1'b1;
    end
    perr_now = perr_now & in_range;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      perr_q <= '0;
    end else begin
      perr_q[0] <= rd_acc & perr_now;
      for (int i = 1; i < LAT; i++) perr_q[i] <= perr_q[i-1];
    end
  end

  assign ParityErr = perr_q[LAT-1];
`endif

  assign ReqReady    = ready_q;
  assign Busy        = busy_q;
  assign ReadValid   = vld_q[LAT-1];
  assign dataOut     = dat_q[LAT-1];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_sync_pipe.sv
// Bench for sram_sync_pipe: a 32-bit/RD_LAT=3 instance against an array-and-queue model,
// plus a small 8-bit/DEPTH=10 instance for the out-of-range address rules.
module tb_sram_sync_pipe;
  import sram_pkg::*;

  localparam int A_W = 32, A_AW = 8, A_DEPTH = 256, A_LAT = 3;
  localparam int B_W = 8,  B_AW = 4, B_DEPTH = 10,  B_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_cs, a_we, a_re, a_ready, a_busy, a_valid;
  logic [A_AW-1:0]   a_addr;
  logic [A_W-1:0]    a_din, a_dout;
  logic [A_W/8-1:0]  a_be;
  sram_state_e       a_state;
  logic              b_cs, b_we, b_re, b_ready, b_busy, b_valid;
  logic [B_AW-1:0]   b_addr;
  logic [B_W-1:0]    b_din, b_dout;
  logic [B_W/8-1:0]  b_be;
  sram_state_e       b_state;
`ifdef SRAM_PARITY_EN
  logic              a_perr, b_perr;
`endif

  sram_sync_pipe #(.DATA_W(A_W), .ADDR_W(A_AW), .DEPTH(A_DEPTH), .RD_LAT(A_LAT)) u_a (
    .Clock(clk), .Reset_n(rst_n), .ChipSelect(a_cs), .WriteEnable(a_we), .ReadEnable(a_re),
    .Addr(a_addr), .dataIn(a_din), .ByteEn(a_be), .ReqReady(a_ready), .Busy(a_busy),
    .dataOut(a_dout), .ReadValid(a_valid),
`ifdef SRAM_PARITY_EN
    .ParityErr(a_perr),
`endif
    .dbg_state_o(a_state)
  );

  sram_sync_pipe #(.DATA_W(B_W), .ADDR_W(B_AW), .DEPTH(B_DEPTH), .RD_LAT(B_LAT)) u_b (
    .Clock(clk), .Reset_n(rst_n), .ChipSelect(b_cs), .WriteEnable(b_we), .ReadEnable(b_re),
    .Addr(b_addr), .dataIn(b_din), .ByteEn(b_be), .ReqReady(b_ready), .Busy(b_busy),
    .dataOut(b_dout), .ReadValid(b_valid),
`ifdef SRAM_PARITY_EN
    .ParityErr(b_perr),
`endif
    .dbg_state_o(b_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: word array, outstanding reads tagged with their due cycle.
  logic [A_W-1:0] mem_m [A_DEPTH];
  bit             corrupt_m [A_DEPTH];
  logic [A_W-1:0] exp_q[$];
  int             due_q[$];
  bit             perr_q[$];
  logic [A_W-1:0] last_out_m;
  int             cyc;
  bit             ready_m, b_ready_m;
  int             clear_left, b_clear_left;

  task automatic a_set(input bit cs, input bit we, input bit re, input logic [A_AW-1:0] addr,
                       input logic [A_W-1:0] din, input logic [A_W/8-1:0] be);
    a_cs = cs; a_we = we; a_re = re; a_addr = addr; a_din = din; a_be = be;
  endtask

  task automatic b_set(input bit cs, input bit we, input bit re, input logic [B_AW-1:0] addr,
                       input logic [B_W-1:0] din);
    b_cs = cs; b_we = we; b_re = re; b_addr = addr; b_din = din; b_be = 1'b1;
  endtask

  task automatic step();
    bit acc;
    acc = a_cs && ready_m && (a_we || a_re);
    if (acc && a_re) begin
      exp_q.push_back(mem_m[a_addr]);
      due_q.push_back(cyc + A_LAT);
      perr_q.push_back(corrupt_m[a_addr]);
    end
    if (acc && a_we) begin
      for (int b = 0; b < A_W / 8; b++) begin
        if (a_be[b]) begin
          mem_m[a_addr][8*b +: 8] = a_din[8*b +: 8];
          if (b == 0) corrupt_m[a_addr] = 1'b0;
        end
      end
    end
    if (!ready_m) begin clear_left--; if (clear_left == 0) ready_m = 1'b1; end
    if (!b_ready_m) begin b_clear_left--; if (b_clear_left == 0) b_ready_m = 1'b1; end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("a_ready", a_ready, ready_m);
    check("a_busy", a_busy, !ready_m);
    check("a_state", a_state, ready_m ? ST_READY : ST_CLEAR);
    check("b_ready", b_ready, b_ready_m);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("a_valid", a_valid, 1'b1);
      last_out_m = exp_q.pop_front();
      void'(due_q.pop_front());
`ifdef SRAM_PARITY_EN
      check("a_perr", a_perr, perr_q[0]);
`endif
      void'(perr_q.pop_front());
    end else begin
      check("a_valid", a_valid, 1'b0);
`ifdef SRAM_PARITY_EN
      check("a_perr_idle", a_perr, 1'b0);
`endif
    end
    check("a_data", a_dout, last_out_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_set(0, 0, 0, '0, '0, '0);
    b_set(0, 0, 0, '0, '0);
    #2;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_a_busy", a_busy, 1'b1);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_data", a_dout, '0);
    check("rst_b_busy", b_busy, 1'b1);
    check("rst_b_data", b_dout, '0);
    exp_q.delete(); due_q.delete(); perr_q.delete();
    for (int i = 0; i < A_DEPTH; i++) begin mem_m[i] = '0; corrupt_m[i] = 1'b0; end
    last_out_m = '0;
    ready_m = 1'b0; clear_left = A_DEPTH;
    b_ready_m = 1'b0; b_clear_left = B_DEPTH;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    a_set(0, 0, 0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic b_read_check(input logic [B_AW-1:0] addr, input logic [B_W-1:0] exp, input string tag);
    b_set(1, 0, 1, addr, '0);
    step();
    check({tag, "_valid"}, b_valid, 1'b1);
    check({tag, "_data"}, b_dout, exp);
  endtask

  logic [A_W-1:0] t2_vals [5];

  initial begin
    cyc = 0;
    t2_vals[0] = 32'h00; t2_vals[1] = 32'h01; t2_vals[2] = 32'h10;
    t2_vals[3] = 32'h06; t2_vals[4] = 32'h12;
    do_reset();

    // Clear sweep: 256 idle cycles of Busy, then a read of a swept word.
    idle(A_DEPTH);
    a_set(1, 0, 1, 8'h7F, '0, '0); step();
    idle(A_LAT);

    // Back-to-back writes then reads.
    for (int i = 0; i < 5; i++) begin a_set(1, 1, 0, 8'(i), t2_vals[i], 4'hF); step(); end
    for (int i = 0; i < 5; i++) begin a_set(1, 0, 1, 8'(i), '0, '0); step(); end
    idle(A_LAT + 1);

    // Byte-lane merge.
    a_set(1, 1, 0, 8'd10, 32'hAABBCCDD, 4'hF); step();
    a_set(1, 1, 0, 8'd10, 32'h11223344, 4'b0101); step();
    a_set(1, 1, 0, 8'd11, 32'hFFFFFFFF, 4'b0000); step();
    a_set(1, 0, 1, 8'd10, '0, '0); step();
    a_set(1, 0, 1, 8'd11, '0, '0); step();
    idle(A_LAT);

    // Read-before-write on the same cycle, then the new word.
    a_set(1, 1, 1, 8'd2, 32'h55, 4'hF); step();
    a_set(1, 0, 1, 8'd2, '0, '0); step();
    idle(A_LAT);

    // Randomized traffic over a small address window to force collisions.
    for (int i = 0; i < 1500; i++) begin
      a_set($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 15)), $urandom, 4'($urandom));
      step();
    end
    idle(A_LAT);

    // Reset with two reads in flight; a write during the sweep is dropped.
    a_set(1, 0, 1, 8'd2, '0, '0); step();
    a_set(1, 0, 1, 8'd3, '0, '0); step();
    do_reset();
    idle(5);
    a_set(1, 1, 0, 8'd6, 32'hDEADBEEF, 4'hF); step();
    idle(A_DEPTH - 6);
    a_set(1, 0, 1, 8'd6, '0, '0); step();
    idle(A_LAT);

    // Small instance: addresses at and beyond DEPTH.
    b_set(1, 1, 0, 4'd12, 8'h5A); step();
    b_set(1, 1, 0, 4'd10, 8'h77); step();
    b_set(1, 1, 0, 4'd5, 8'h3C); step();
    b_set(1, 1, 0, 4'd9, 8'hC3); step();
    b_read_check(4'd12, 8'h00, "b_oor12");
    b_read_check(4'd5, 8'h3C, "b_rd5");
    b_read_check(4'd10, 8'h00, "b_oor10");
    b_read_check(4'd9, 8'hC3, "b_rd9");
    b_set(0, 0, 0, '0, '0); step();
    check("b_idle_valid", b_valid, 1'b0);
    check("b_hold_data", b_dout, 8'hC3);

`ifdef SRAM_PARITY_EN
    a_set(1, 1, 0, 8'd3, $urandom, 4'hF); step();
    a_set(1, 1, 0, 8'd4, $urandom, 4'hF); step();
    u_a.u_array.mem_q[3][0][8] = ~u_a.u_array.mem_q[3][0][8];
    corrupt_m[3] = 1'b1;
    a_set(1, 0, 1, 8'd3, '0, '0); step();
    a_set(1, 0, 1, 8'd4, '0, '0); step();
    idle(A_LAT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
